bpsk_correlator: RTL and testbench
==================================

Name: bpsk_correlator

Overview:
Receive-side counterpart to the transmit carrier path. Multiplies incoming baseband/IF samples by the local carrier from an internal cosine_lut (READ_PORTS=1) and accumulates over one carrier period. It then emits one hard BPSK bit decision per period, plus the raw correlation value. It sits between the ADC sample stream and the bit deframer in the receiver chain.

Parameters:
SAMPLES_PER_SYM, `CARRIER_SAMPLES_PER_PERIOD, samples per symbol; equals the LUT depth.
LUT_WIDTH, `FIXDT_64_A_WIDTH, signed width of the cosine_lut output.
SAMPLE_WIDTH, 12, signed input sample width.
PHASE_WIDTH, $clog2(SAMPLES_PER_SYM), phase index width.
ACC_WIDTH, SAMPLE_WIDTH+LUT_WIDTH+$clog2(SAMPLES_PER_SYM), accumulator and corr_out width.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
sample_valid  in  1  sample_in valid this cycle
sample_in  in  SAMPLE_WIDTH  signed two's-complement sample
sync  in  1  symbol-boundary strobe; next accepted sample is phase 0
bit_valid  out  1  one-cycle pulse, decision available
bit_out  out  1  hard decision, valid with bit_valid
corr_out  out  ACC_WIDTH  signed full-period correlation, valid with bit_valid
phase_out  out  PHASE_WIDTH  current phase index (debug)

Behaviour:
- Clocking and reset: one clock domain (clk). Reset is synchronous and active-high (rst); the polarity and synchronicity are fixed.
- Reset values: bit_valid=0, bit_out=0, corr_out=0, phase_out=0. The phase counter, accumulator and all pipeline valid/first/last flags clear.
- Phase counter:
  - Advances only on accepted samples (sample_valid=1).
  - Wraps from SAMPLES_PER_SYM-1 to 0.
  - Holds during sample_valid=0 gaps.
- Phase index for an accepted sample is 0 if sync=1 in that cycle; otherwise it is the counter value. The counter then becomes index+1, with wrap.
- sync with sample_valid=0: counter forced to 0 and the in-flight partial symbol is discarded. The pipeline first flag is raised for the next accepted sample.
- Pipeline of 3 register stages, edges E, E+1, E+2 for a sample accepted at edge E:
  - S1 (edge E): register sample, LUT[phase], valid, first (index==0), last (index==SAMPLES_PER_SYM-1).
  - S2 (edge E+1): product = signed sample × signed cos, full width SAMPLE_WIDTH+LUT_WIDTH, no truncation. Flags propagate.
  - S3 (edge E+2): if valid, acc <= first ? sign-extended product : acc + product. If valid and last, corr_out <= the new acc value and bit_out <= (new acc > 0). bit_valid=1 for exactly the cycle after edge E+2, otherwise 0.
- Decision rule: strictly positive correlation gives 1; zero or negative gives 0.
- corr_out and bit_out hold their values between pulses.
- Bubbles (sample_valid=0) travel as valid=0 and leave acc unchanged. Any gap pattern yields the same corr_out as a gapless stream.
- A symbol truncated by sync never produces bit_valid. Accumulation restarts at the phase-0 sample.
- ACC_WIDTH guarantees no overflow for full-scale inputs. No saturation logic.
- rst mid-symbol: in-flight samples are dropped, no bit_valid is emitted for them, and the counter restarts at phase 0.
- rst has priority over sync and sample_valid in the same cycle.

Test Plan:
- Matched carrier: sync on the first sample, then SAMPLES_PER_SYM gapless samples with sample_in = LUT[i]>>(LUT_WIDTH-SAMPLE_WIDTH). Expect exactly one bit_valid, 3 edges after the last sample, with bit_out=1 and corr_out = model Σ sample_i·LUT[i].
- Inverted carrier: same stimulus, negated. Expect bit_out=0 and corr_out equal to the exact negation of the matched case.
- Zero input: a full period of sample_in=0. Expect bit_valid=1, corr_out=0, bit_out=0.
- Gaps and wrap: two back-to-back symbols with random sample_valid gaps (≈30% idle). Expect two pulses, corr_out identical to the gapless model, and phase_out back at 0 after each period.
- Resync: sync asserted at phase 100 of a symbol. Expect no pulse for the partial symbol and the next pulse after SAMPLES_PER_SYM further accepted samples. Also check sync together with sample_valid (sample used as phase 0).
- Reset mid-symbol: rst for 1 cycle at phase 50 with samples in the pipeline. Expect all outputs 0, no stray bit_valid, and phase_out=0 next cycle. The following full symbol decodes correctly.

Source files
------------

// File: rtl/bpsk_correlator.sv
// BPSK correlator: multiplies each accepted sample by the local cosine carrier and integrates
// over one carrier period. It emits a hard bit decision and the raw correlation once per period.
`ifndef CARRIER_SAMPLES_PER_PERIOD
`define CARRIER_SAMPLES_PER_PERIOD 128
`endif
`ifndef FIXDT_64_A_WIDTH
`define FIXDT_64_A_WIDTH 16
`endif

module bpsk_correlator #(
    parameter int SAMPLES_PER_SYM = `CARRIER_SAMPLES_PER_PERIOD,
    parameter int LUT_WIDTH       = `FIXDT_64_A_WIDTH,
    parameter int SAMPLE_WIDTH    = 12,
    parameter int PHASE_WIDTH     = $clog2(SAMPLES_PER_SYM),
    parameter int ACC_WIDTH       = SAMPLE_WIDTH + LUT_WIDTH + $clog2(SAMPLES_PER_SYM)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           sample_valid,
    input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                           sync,
    output logic                           bit_valid,
    output logic                           bit_out,
    output logic signed [ACC_WIDTH-1:0]    corr_out,
    output logic [PHASE_WIDTH-1:0]         phase_out
);

    localparam int PROD_WIDTH = SAMPLE_WIDTH + LUT_WIDTH;
    localparam logic [PHASE_WIDTH-1:0] LAST_PHASE = PHASE_WIDTH'(SAMPLES_PER_SYM - 1);

    // One full cosine period, amplitude 2^(LUT_WIDTH-1)-1, rounded half away from zero.
    function automatic logic signed [LUT_WIDTH-1:0] cos_entry(input int idx);
        real amp;
        real ang;
        real val;
        amp = real'((1 << (LUT_WIDTH - 1)) - 1);
        ang = 6.283185307179586 * real'(idx) / real'(SAMPLES_PER_SYM);
        val = amp * $cos(ang);
        if (val >= 0.0) begin
            return LUT_WIDTH'($rtoi(val + 0.5));
        end
        return LUT_WIDTH'($rtoi(val - 0.5));
    endfunction

    logic signed [LUT_WIDTH-1:0] cos_rom [SAMPLES_PER_SYM];

    generate
        for (genvar gi = 0; gi < SAMPLES_PER_SYM; gi++) begin : g_cos_rom
            assign cos_rom[gi] = cos_entry(gi);
        end
    endgenerate

    logic [PHASE_WIDTH-1:0] phase_q, phase_d;
    logic [PHASE_WIDTH-1:0] phase_idx;

    logic                           s1_valid_q, s1_first_q, s1_last_q;
    logic signed [SAMPLE_WIDTH-1:0] s1_sample_q;
    logic signed [LUT_WIDTH-1:0]    s1_cos_q;

    logic                         s2_valid_q, s2_first_q, s2_last_q;
    logic signed [PROD_WIDTH-1:0] s2_prod_q;

    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic signed [ACC_WIDTH-1:0] corr_q;
    logic                        bit_q, bit_d;
    logic                        bit_valid_q;

    // sync forces this sample (or the next accepted one) to phase 0.
    always_comb begin
        phase_idx = sync ? '0 : phase_q;
        phase_d   = phase_q;
        if (sample_valid) begin
            phase_d = (phase_idx == LAST_PHASE) ? '0 : phase_idx + PHASE_WIDTH'(1);
        end else if (sync) begin
            phase_d = '0;
        end
    end

    always_comb begin
        acc_d = {{(ACC_WIDTH - PROD_WIDTH){s2_prod_q[PROD_WIDTH-1]}}, s2_prod_q};
        if (!s2_first_q) begin
            acc_d = acc_q + acc_d;
        end
        bit_d = !acc_d[ACC_WIDTH-1] && (acc_d != '0);
    end

    // Carrier ROM read register kept free of reset so it maps onto block memory.
    always_ff @(posedge clk) begin
        s1_cos_q    <= cos_rom[phase_idx];
        s1_sample_q <= sample_in;
        s2_prod_q   <= s1_sample_q * s1_cos_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q     <= '0;
            s1_valid_q  <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_first_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            acc_q       <= '0;
            corr_q      <= '0;
            bit_q       <= 1'b0;
            bit_valid_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            s1_valid_q  <= sample_valid;
            s1_first_q  <= sample_valid && (phase_idx == '0);
            s1_last_q   <= sample_valid && (phase_idx == LAST_PHASE);
            s2_valid_q  <= s1_valid_q;
            s2_first_q  <= s1_first_q;
            s2_last_q   <= s1_last_q;
            if (s2_valid_q) begin
                acc_q <= acc_d;
                if (s2_last_q) begin
                    corr_q <= acc_d;
                    bit_q  <= bit_d;
                end
            end
            bit_valid_q <= s2_valid_q && s2_last_q;
        end
    end

    assign bit_valid = bit_valid_q;
    assign bit_out   = bit_q;
    assign corr_out  = corr_q;
    assign phase_out = phase_q;

endmodule

// File: tb/tb_bpsk_correlator.sv
// Scoreboarded bench for bpsk_correlator: the driver pushes the expected correlation per full
// symbol, and a negedge monitor pops and compares on every bit_valid pulse.
module tb_bpsk_correlator;

    localparam int N  = 128;
    localparam int LW = 16;
    localparam int SW = 12;
    localparam int PW = 7;
    localparam int AW = SW + LW + PW;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 sample_valid = 1'b0;
    logic                 sync = 1'b0;
    logic signed [SW-1:0] sample_in = '0;
    logic                 bit_valid;
    logic                 bit_out;
    logic signed [AW-1:0] corr_out;
    logic [PW-1:0]        phase_out;

    bpsk_correlator #(
        .SAMPLES_PER_SYM(N),
        .LUT_WIDTH      (LW),
        .SAMPLE_WIDTH   (SW),
        .PHASE_WIDTH    (PW),
        .ACC_WIDTH      (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_valid(sample_valid),
        .sample_in   (sample_in),
        .sync        (sync),
        .bit_valid   (bit_valid),
        .bit_out     (bit_out),
        .corr_out    (corr_out),
        .phase_out   (phase_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef int sym_t [N];
    typedef struct {
        longint corr;
        logic   bitv;
        int     edge_n;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   lut [N];
    int   errors = 0;
    int   checks = 0;
    int   pulses = 0;
    int   pushed = 0;

    function automatic int lut_val(input int i);
        real v;
        v = 32767.0 * $cos(2.0 * 3.141592653589793 * real'(i) / real'(N));
        return (v >= 0.0) ? $rtoi(v + 0.5) : $rtoi(v - 0.5);
    endfunction

    function automatic longint model(input sym_t s);
        longint acc = 0;
        for (int i = 0; i < N; i++) acc += longint'(s[i]) * longint'(lut[i]);
        return acc;
    endfunction

    task automatic check(input string name, input longint act, input longint expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input bit s, input int x);
        sample_valid = v;
        sync         = s;
        sample_in    = SW'(x);
        tick();
    endtask

    task automatic send_partial(input sym_t s, input int count, input bit use_sync);
        for (int i = 0; i < count; i++) drive(1'b1, use_sync && (i == 0), s[i]);
        sample_valid = 1'b0;
        sync         = 1'b0;
    endtask

    task automatic send_symbol(input sym_t s, input bit use_sync, input bit gaps, input string name);
        exp_t e;
        for (int i = 0; i < N; i++) begin
            int idle = 0;
            while (gaps && (idle < 8) && ($urandom_range(0, 99) < 30)) begin
                drive(1'b0, 1'b0, 0);
                idle++;
            end
            drive(1'b1, use_sync && (i == 0), s[i]);
        end
        e.corr   = model(s);
        e.bitv   = (e.corr > 0);
        e.edge_n = cyc + 2;
        exp_q.push_back(e);
        pushed++;
        $display("symbol %s: expect corr=%0d bit=%0d at cycle %0d", name, e.corr, e.bitv, e.edge_n);
        check({name, "_phase_wrap"}, longint'(phase_out), 0);
        sample_valid = 1'b0;
        sync         = 1'b0;
    endtask

    always @(negedge clk) begin
        if (bit_valid === 1'b1) begin
            pulses++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stray_pulse: got bit_valid=1 at cycle %0d, expected none", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                $display("pulse at cycle %0d: corr=%0d bit=%0d", cyc, corr_out, bit_out);
                check("corr_out", longint'(corr_out), mon_e.corr);
                check("bit_out", longint'(bit_out), longint'(mon_e.bitv));
                check("pulse_cycle", longint'(cyc), longint'(mon_e.edge_n));
            end
        end
    end

    sym_t matched, inverted, zeros, alt;

    initial begin
        for (int i = 0; i < N; i++) begin
            lut[i] = lut_val(i);
            // Truncate toward zero so the negated stream stays inside the 12-bit range.
            matched[i]  = lut[i] / 16;
            inverted[i] = -matched[i];
            zeros[i]    = 0;
            alt[i]      = ((i % 3) == 0) ? -700 : 350;
        end

        rst = 1'b1;
        repeat (3) tick();
        check("reset_bit_valid", longint'(bit_valid), 0);
        check("reset_bit_out", longint'(bit_out), 0);
        check("reset_corr_out", longint'(corr_out), 0);
        check("reset_phase_out", longint'(phase_out), 0);
        rst = 1'b0;
        repeat (2) tick();

        send_symbol(matched, 1'b1, 1'b0, "matched");
        repeat (5) drive(1'b0, 1'b0, 0);
        send_symbol(inverted, 1'b1, 1'b0, "inverted");
        repeat (5) drive(1'b0, 1'b0, 0);
        send_symbol(zeros, 1'b1, 1'b0, "zero");
        repeat (5) drive(1'b0, 1'b0, 0);

        send_symbol(matched, 1'b1, 1'b1, "gap1");
        send_symbol(inverted, 1'b0, 1'b1, "gap2");
        repeat (5) drive(1'b0, 1'b0, 0);

        // Truncated symbol, sync on an idle cycle, another partial, then sync with a valid sample.
        send_partial(matched, 100, 1'b1);
        check("pre_sync_phase", longint'(phase_out), 100);
        drive(1'b0, 1'b1, 0);
        check("sync_idle_phase", longint'(phase_out), 0);
        send_partial(inverted, 40, 1'b0);
        check("partial_phase", longint'(phase_out), 40);
        send_symbol(alt, 1'b1, 1'b0, "resync");
        repeat (5) drive(1'b0, 1'b0, 0);

        send_partial(matched, 50, 1'b1);
        rst = 1'b1;
        drive(1'b1, 1'b0, 123);
        rst = 1'b0;
        check("rst_bit_valid", longint'(bit_valid), 0);
        check("rst_bit_out", longint'(bit_out), 0);
        check("rst_corr_out", longint'(corr_out), 0);
        check("rst_phase_out", longint'(phase_out), 0);
        sample_valid = 1'b0;
        repeat (5) drive(1'b0, 1'b0, 0);
        send_symbol(inverted, 1'b0, 1'b0, "post_reset");
        repeat (8) drive(1'b0, 1'b0, 0);

        check("pending_expectations", longint'(exp_q.size()), 0);
        check("pulse_count", longint'(pulses), longint'(pushed));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
